// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// mips_multicycle_ctrl : multi-cycle control FSM for the MIPS-subset datapath
// Optional macro OVERFLOW_TRAP_EN adds an overflow trap in writeback.
// Revision: 1.0
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_funct,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_src,
  output logic        illegal_instr,
  output logic        bus_error,
`ifdef OVERFLOW_TRAP_EN
  output logic        overflow_trap,
`endif
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IFETCH  = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4
  } state_t;

  localparam logic [5:0] cOpRtype = 6'h00;
  localparam logic [5:0] cOpJ     = 6'h02;
  localparam logic [5:0] cOpJal   = 6'h03;
  localparam logic [5:0] cOpBeq   = 6'h04;
  localparam logic [5:0] cOpBne   = 6'h05;
  localparam logic [5:0] cOpAddi  = 6'h08;
  localparam logic [5:0] cOpXori  = 6'h0E;
  localparam logic [5:0] cOpLw    = 6'h23;
  localparam logic [5:0] cOpSw    = 6'h2B;
  localparam logic [5:0] cFnJr    = 6'h08;
  localparam logic [5:0] cFnAdd   = 6'h20;
  localparam logic [5:0] cFnSub   = 6'h22;
  localparam logic [5:0] cFnSlt   = 6'h2A;

  localparam int CNT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;

  state_t           rState;
  state_t           wStateNext;
  logic [5:0]       rOpcode;
  logic [5:0]       rFunct;
  logic [CNT_W-1:0] rWaitCnt;

  logic wIsR, wIsJ, wIsJal, wIsJr, wIsBeq, wIsBne, wIsAddi, wIsXori, wIsLw, wIsSw;
  logic wIsAdd, wIsSub, wIsSlt, wLegal, wWaiting, wTimeout;
  logic wTrap;

  assign wIsR    = (rOpcode == cOpRtype);
  assign wIsJ    = (rOpcode == cOpJ);
  assign wIsJal  = (rOpcode == cOpJal);
  assign wIsBeq  = (rOpcode == cOpBeq);
  assign wIsBne  = (rOpcode == cOpBne);
  assign wIsAddi = (rOpcode == cOpAddi);
  assign wIsXori = (rOpcode == cOpXori);
  assign wIsLw   = (rOpcode == cOpLw);
  assign wIsSw   = (rOpcode == cOpSw);
  assign wIsJr   = wIsR && (rFunct == cFnJr);
  assign wIsAdd  = wIsR && (rFunct == cFnAdd);
  assign wIsSub  = wIsR && (rFunct == cFnSub);
  assign wIsSlt  = wIsR && (rFunct == cFnSlt);
  assign wLegal  = wIsJr || wIsAdd || wIsSub || wIsSlt || wIsJ || wIsJal || wIsBeq ||
                   wIsBne || wIsAddi || wIsXori || wIsLw || wIsSw;

  // The timeout fires on the WAIT_LIMIT-th consecutive stalled cycle.
  assign wWaiting = ((rState == IFETCH) || (rState == MEM)) && !mem_ready;
  assign wTimeout = (WAIT_LIMIT != 0) && wWaiting && (int'(rWaitCnt) == WAIT_LIMIT - 1);

  assign alu_opcode = rOpcode;
  assign alu_funct  = rFunct;
  assign state_o    = rState;

`ifdef OVERFLOW_TRAP_EN
  logic unusedBits;
  assign unusedBits = ^mem_rdata[25:6];
`else
  logic unusedBits;
  assign unusedBits = ^{mem_rdata[25:6], alu_overflow};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rState   <= IFETCH;
      rOpcode  <= 6'd0;
      rFunct   <= 6'd0;
      rWaitCnt <= '0;
    end else begin
      rState <= wStateNext;
      if ((rState == IFETCH) && mem_ready) begin
        rOpcode <= mem_rdata[31:26];
        rFunct  <= mem_rdata[5:0];
      end
      rWaitCnt <= (wWaiting && !wTimeout) ? rWaitCnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    wStateNext    = rState;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'd0;
    alu_src_b     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'd0;
    wb_src        = 2'd0;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;
    wTrap         = 1'b0;
    case (rState)
      IFETCH: begin
        if (wTimeout) begin
          bus_error  = 1'b1;
          wStateNext = IFETCH;
        end else begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            wStateNext = DECODE;
          end
        end
      end
      DECODE: begin
        wStateNext = IFETCH;
        if (!wLegal) begin
          illegal_instr = 1'b1;
        end else if (wIsJ) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end else if (wIsJal) begin
          reg_write = 1'b1;
          reg_dst   = 2'd2;
          wb_src    = 2'd2;
          pc_write  = 1'b1;
          pc_src    = 2'd2;
        end else if (wIsJr) begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
        end else begin
          wStateNext = EXECUTE;
        end
      end
      EXECUTE: begin
        alu_src_b = wIsLw || wIsSw || wIsAddi || wIsXori;
        if (wIsBeq || wIsBne) begin
          pc_write   = wIsBeq ? alu_zero : !alu_zero;
          pc_src     = 2'd1;
          wStateNext = IFETCH;
        end else if (wIsLw || wIsSw) begin
          wStateNext = MEM;
        end else begin
          wStateNext = WB;
        end
      end
      MEM: begin
        iord = 1'b1;
        if (wTimeout) begin
          bus_error  = 1'b1;
          wStateNext = IFETCH;
        end else begin
          mem_read  = wIsLw;
          mem_write = wIsSw;
          if (mem_ready) wStateNext = wIsLw ? WB : IFETCH;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = wIsR ? 2'd1 : 2'd0;
        wb_src     = wIsLw ? 2'd1 : 2'd0;
        wStateNext = IFETCH;
`ifdef OVERFLOW_TRAP_EN
        if ((wIsAdd || wIsSub || wIsAddi) && alu_overflow) begin
          reg_write = 1'b0;
          wTrap     = 1'b1;
        end
`endif
      end
      default: wStateNext = IFETCH;
    endcase
    // Reset aborts the current operation without side effects.
    if (reset) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      bus_error     = 1'b0;
      wTrap         = 1'b0;
    end
  end

`ifdef OVERFLOW_TRAP_EN
  assign overflow_trap = wTrap;
`else
  logic unusedTrap;
  assign unusedTrap = wTrap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mips_multicycle_ctrl : instruction-level model builds per-cycle
// expectations; one process drives them and checks the DUT every cycle.
// ============================================================================
module tb_mips_multicycle_ctrl;
  localparam int LIM = 4;
`ifdef OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] mem_rdata = 32'd0;
  logic mem_ready = 1'b0, alu_zero = 1'b0, alu_overflow = 1'b0;
  logic [5:0] alu_opcode, alu_funct;
  logic mem_read, mem_write, iord, ir_write, pc_write, alu_src_b, reg_write;
  logic [1:0] pc_src, reg_dst, wb_src;
  logic illegal_instr, bus_error;
  logic [2:0] state_o;
`ifdef OVERFLOW_TRAP_EN
  logic overflow_trap;
`endif

  mips_multicycle_ctrl #(.WAIT_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_opcode(alu_opcode), .alu_funct(alu_funct),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_src(wb_src),
    .illegal_instr(illegal_instr), .bus_error(bus_error),
`ifdef OVERFLOW_TRAP_EN
    .overflow_trap(overflow_trap),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus expected outputs; -1 marks "not defined here".
  typedef struct {
    bit rst; logic [31:0] rdata; bit ready; bit zero; bit ovf;
    int st; int mrd; int mwr; int iord; int irw; int pcw; int pcs; int asb;
    int rgw; int rdst; int wbs; int ill; int berr; int trap; int aop; int afn;
  } cyc_t;

  cyc_t q[$];
  int checks = 0, errors = 0;
  int curOp = 0, curFunct = 0;
  int stTrace[$];
  int illCnt = 0, berrCnt = 0, memAccCnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t base(input int st);
    cyc_t c;
    c.rst = 1'b0; c.rdata = $urandom; c.ready = ($urandom_range(0, 1) == 1);
    c.zero = ($urandom_range(0, 1) == 1); c.ovf = ($urandom_range(0, 1) == 1);
    c.st = st; c.mrd = 0; c.mwr = 0; c.irw = 0; c.pcw = 0; c.rgw = 0;
    c.ill = 0; c.berr = 0; c.trap = 0;
    c.iord = -1; c.pcs = -1; c.asb = -1; c.rdst = -1; c.wbs = -1;
    c.aop = curOp; c.afn = curFunct;
    return c;
  endfunction

  task automatic pushReset(input int st);
    cyc_t c;
    c = base(st);
    c.rst = 1'b1;
    q.push_back(c);
    curOp = 0;
    curFunct = 0;
  endtask

  task automatic pushBusErr(input int st);
    cyc_t c;
    c = base(st);
    c.ready = 1'b0;
    c.berr = 1;
    q.push_back(c);
  endtask

  // Appends the cycles one instruction takes, from fetch until back in fetch.
  task automatic gen(input logic [31:0] instr, input int fetchWaits, input int memWaits,
                     input bit zero, input bit ovf, input int abortSt);
    cyc_t c;
    int op, fn, cnt, left;
    bit isR, lw, sw, legal;
    op = int'(instr[31:26]);
    fn = int'(instr[5:0]);
    isR = (op == 0);
    lw = (op == 'h23);
    sw = (op == 'h2B);
    legal = (isR && (fn == 'h20 || fn == 'h22 || fn == 'h2A || fn == 'h08)) ||
            op == 'h02 || op == 'h03 || op == 'h04 || op == 'h05 ||
            op == 'h08 || op == 'h0E || lw || sw;
    if (abortSt == 0) begin pushReset(0); return; end
    cnt = 0;
    left = fetchWaits;
    while (left > 0) begin
      cnt++;
      left--;
      if (cnt == LIM) begin
        pushBusErr(0);
        cnt = 0;
      end else begin
        c = base(0); c.ready = 1'b0; c.mrd = 1; c.iord = 0;
        q.push_back(c);
      end
    end
    c = base(0); c.ready = 1'b1; c.rdata = instr;
    c.mrd = 1; c.iord = 0; c.irw = 1; c.pcw = 1; c.pcs = 0;
    q.push_back(c);
    curOp = op;
    curFunct = fn;
    if (abortSt == 1) begin pushReset(1); return; end
    c = base(1);
    if (!legal) begin
      c.ill = 1; q.push_back(c); return;
    end else if (op == 'h02) begin
      c.pcw = 1; c.pcs = 2; q.push_back(c); return;
    end else if (op == 'h03) begin
      c.rgw = 1; c.rdst = 2; c.wbs = 2; c.pcw = 1; c.pcs = 2; q.push_back(c); return;
    end else if (isR && fn == 'h08) begin
      c.pcw = 1; c.pcs = 3; q.push_back(c); return;
    end
    q.push_back(c);
    if (abortSt == 2) begin pushReset(2); return; end
    c = base(2);
    c.asb = (lw || sw || op == 'h08 || op == 'h0E) ? 1 : 0;
    if (op == 'h04 || op == 'h05) begin
      c.zero = zero;
      c.pcs = 1;
      c.pcw = (op == 'h04) ? int'(zero) : int'(!zero);
      q.push_back(c);
      return;
    end
    q.push_back(c);
    if (lw || sw) begin
      if (abortSt == 3) begin pushReset(3); return; end
      for (int i = 1; i <= memWaits; i++) begin
        if (i == LIM) begin pushBusErr(3); return; end
        c = base(3); c.ready = 1'b0; c.iord = 1; c.mrd = lw; c.mwr = sw;
        q.push_back(c);
      end
      c = base(3); c.ready = 1'b1; c.iord = 1; c.mrd = lw; c.mwr = sw;
      q.push_back(c);
      if (sw) return;
    end
    if (abortSt == 4) begin pushReset(4); return; end
    c = base(4);
    c.ovf = ovf; c.rgw = 1; c.rdst = isR ? 1 : 0; c.wbs = lw ? 1 : 0;
    if (TRAP && ovf && ((isR && (fn == 'h20 || fn == 'h22)) || op == 'h08)) begin
      c.rgw = 0;
      c.trap = 1;
    end
    q.push_back(c);
  endtask

  task automatic runQueue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      reset = c.rst; mem_rdata = c.rdata; mem_ready = c.ready;
      alu_zero = c.zero; alu_overflow = c.ovf;
      #2;
      chk("state_o", int'(state_o), c.st);
      chk("mem_read", int'(mem_read), c.mrd);
      chk("mem_write", int'(mem_write), c.mwr);
      chk("iord", int'(iord), c.iord);
      chk("ir_write", int'(ir_write), c.irw);
      chk("pc_write", int'(pc_write), c.pcw);
      chk("pc_src", int'(pc_src), c.pcs);
      chk("alu_src_b", int'(alu_src_b), c.asb);
      chk("reg_write", int'(reg_write), c.rgw);
      chk("reg_dst", int'(reg_dst), c.rdst);
      chk("wb_src", int'(wb_src), c.wbs);
      chk("illegal_instr", int'(illegal_instr), c.ill);
      chk("bus_error", int'(bus_error), c.berr);
      chk("alu_opcode", int'(alu_opcode), c.aop);
      chk("alu_funct", int'(alu_funct), c.afn);
`ifdef OVERFLOW_TRAP_EN
      chk("overflow_trap", int'(overflow_trap), c.trap);
`endif
      stTrace.push_back(int'(state_o));
      if (illegal_instr) illCnt++;
      if (bus_error) berrCnt++;
      if (state_o == 3'd3 && mem_read && iord) memAccCnt++;
    end
  endtask

  initial begin
    int expTr[4];
    logic [31:0] instr;
    int k, abortSt;
    int ops[12];
    int badOps[4];
    expTr = '{0, 1, 2, 4};
    ops = '{'h20, 'h22, 'h2A, 'h08, 'h23, 'h2B, 'h02, 'h03, 'h04, 'h05, 'h08, 'h0E};
    badOps = '{'h01, 'h3F, 'h0F, 'h20};

    pushReset(0);
    pushReset(0);
    runQueue();

    stTrace.delete();
    gen(32'h00221820, 0, 0, 1'b0, 1'b0, -1);
    runQueue();
    chk("addTraceLen", stTrace.size(), 4);
    for (int i = 0; i < 4 && i < stTrace.size(); i++) chk("addTrace", stTrace[i], expTr[i]);
    chk("addOpcode", int'(alu_opcode), 'h00);
    chk("addFunct", int'(alu_funct), 'h20);

    memAccCnt = 0;
    gen(32'h8C220004, 0, 2, 1'b0, 1'b0, -1);
    runQueue();
    chk("lwMemCycles", memAccCnt, 3);

    gen(32'h10220003, 0, 0, 1'b1, 1'b0, -1);
    gen(32'h10220003, 0, 0, 1'b0, 1'b0, -1);
    gen(32'h14220003, 0, 0, 1'b1, 1'b0, -1);
    gen(32'h14220003, 0, 0, 1'b0, 1'b0, -1);
    gen(32'h0C000010, 0, 0, 1'b0, 1'b0, -1);
    runQueue();

    illCnt = 0;
    gen(32'hFC000000, 0, 0, 1'b0, 1'b0, -1);
    gen(32'h00000025, 0, 0, 1'b0, 1'b0, -1);
    runQueue();
    chk("illegalPulses", illCnt, 2);

    berrCnt = 0;
    gen(32'h00221820, LIM, 0, 1'b0, 1'b0, -1);
    runQueue();
    chk("busErrPulses", berrCnt, 1);

    gen(32'hAC220004, 0, 1, 1'b0, 1'b0, 3);
    gen(32'h20010001, 0, 0, 1'b0, 1'b1, -1);
    gen(32'h00221820, 0, 0, 1'b0, 1'b1, -1);
    runQueue();

    for (int n = 0; n < 300; n++) begin
      instr = $urandom;
      k = $urandom_range(0, 15);
      if (k < 4) begin
        instr[31:26] = 6'h00; instr[5:0] = 6'(ops[k]);
      end else if (k < 12) begin
        instr[31:26] = 6'(ops[k]);
      end else if (k == 12) begin
        instr[31:26] = 6'(badOps[$urandom_range(0, 3)]);
      end else if (k == 13) begin
        instr[31:26] = 6'h00; instr[5:0] = ($urandom_range(0, 1) == 1) ? 6'h25 : 6'h00;
      end else begin
        instr[31:26] = (k == 14) ? 6'h23 : 6'h2B;
      end
      abortSt = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 4)) : -1;
      gen(instr,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0,
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), abortSt);
      runQueue();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
